// File: rtl/fadd_stim_gen.sv
// Stimulus sequencer for binary FPU operators (fadd, fmul, fsub).
// On start it streams operand pairs through fixed phases: both-zero, op1-zero,
// op2-zero, op1-huge, op2-huge, random. The pairs come from an xorshift32
// generator that is reloaded from SEED on every start.
//
// Handshake: valid is high while a pair sits on op1/op2. A pair transfers on a
// rising clk edge where valid && ready. While valid && !ready, op1, op2, phase
// and vec_idx hold. ready is ignored while valid is low. After a transfer the
// next pair appears in the following cycle, so the stream has no bubbles.
module fadd_stim_gen #(
    parameter int          EXP_W  = 8,
    parameter int          FRAC_W = 23,
    parameter int          N_ZERO = 1000,
    parameter int          N_BIG  = 1000,
    parameter int          N_RAND = 10000,
    parameter logic [31:0] SEED   = 32'h00000001
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    ready,
    output logic                    valid,
    output logic [EXP_W+FRAC_W:0]   op1,
    output logic [EXP_W+FRAC_W:0]   op2,
    output logic [2:0]              phase,
    output logic [31:0]             vec_idx,
    output logic                    busy,
    output logic                    done
);

    localparam int          W        = 1 + EXP_W + FRAC_W;
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    // Phase encoding is also the externally visible phase code.
    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_ZZ   = 3'd1,
        PH_Z1   = 3'd2,
        PH_Z2   = 3'd3,
        PH_B1   = 3'd4,
        PH_B2   = 3'd5,
        PH_RND  = 3'd6,
        PH_DONE = 3'd7
    } phase_t;

    phase_t            phase_q, phase_n;
    logic [31:0]       cnt_q, cnt_n;
    logic [31:0]       s_q, s_n;
    logic [W-1:0]      op1_q, op1_n;
    logic [W-1:0]      op2_q, op2_n;
    logic [31:0]       vidx_q, vidx_n;

    logic [31:0]       ra_c, rb_c, s_adv, na_c, nb_c;
    logic              run_c, last_c;

    // One xorshift32 step.
    function automatic logic [31:0] xs32(input logic [31:0] v);
        logic [31:0] x;
        x = v;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    // Keep sign and fraction, force the exponent to the largest finite value.
    function automatic logic [W-1:0] force_big(input logic [31:0] v);
        logic [W-1:0] r;
        r = v[W-1:0];
        r[W-2 -: EXP_W] = {{(EXP_W-1){1'b1}}, 1'b0};
        return r;
    endfunction

    // Number of vectors emitted in a busy phase.
    function automatic logic [31:0] phase_len(input phase_t p);
        logic [31:0] n;
        case (p)
            PH_ZZ:         n = 32'd1;
            PH_Z1, PH_Z2:  n = 32'(N_ZERO);
            PH_B1, PH_B2:  n = 32'(N_BIG);
            PH_RND:        n = 32'(N_RAND);
            default:       n = 32'd1;
        endcase
        return n;
    endfunction

    // Operand 1 shaping for a pair drawn in phase p.
    function automatic logic [W-1:0] shape_op1(input phase_t p, input logic [31:0] a);
        logic [W-1:0] r;
        case (p)
            PH_B1:                 r = force_big(a);
            PH_Z2, PH_B2, PH_RND:  r = a[W-1:0];
            default:               r = '0;
        endcase
        return r;
    endfunction

    // Operand 2 shaping for a pair drawn in phase p.
    function automatic logic [W-1:0] shape_op2(input phase_t p, input logic [31:0] b);
        logic [W-1:0] r;
        case (p)
            PH_B2:                 r = force_big(b);
            PH_Z1, PH_B1, PH_RND:  r = b[W-1:0];
            default:               r = '0;
        endcase
        return r;
    endfunction

    // State register: phase, per-phase counter, generator and output pair.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            s_q     <= SEED_EFF;
            op1_q   <= '0;
            op2_q   <= '0;
            vidx_q  <= '0;
        end else begin
            phase_q <= phase_n;
            cnt_q   <= cnt_n;
            s_q     <= s_n;
            op1_q   <= op1_n;
            op2_q   <= op2_n;
            vidx_q  <= vidx_n;
        end
    end

    // Next-state: start handling, transfer accounting, phase stepping and the
    // pair that follows the current one. ZZ draws nothing from the generator,
    // so its successor is built from the unadvanced state.
    always_comb begin
        phase_n = phase_q;
        cnt_n   = cnt_q;
        s_n     = s_q;
        op1_n   = op1_q;
        op2_n   = op2_q;
        vidx_n  = vidx_q;

        run_c   = (phase_q != PH_IDLE) && (phase_q != PH_DONE);
        last_c  = (cnt_q == phase_len(phase_q) - 32'd1);
        ra_c    = xs32(s_q);
        rb_c    = xs32(ra_c);
        s_adv   = (phase_q == PH_ZZ) ? s_q : rb_c;
        na_c    = xs32(s_adv);
        nb_c    = xs32(na_c);

        if (!run_c) begin
            if (start) begin
                phase_n = PH_ZZ;
                cnt_n   = '0;
                s_n     = SEED_EFF;
                op1_n   = '0;
                op2_n   = '0;
                vidx_n  = '0;
            end
        end else if (ready) begin
            s_n = s_adv;
            if (vidx_q != 32'hFFFF_FFFF) begin
                vidx_n = vidx_q + 32'd1;
            end
            if (last_c) begin
                phase_n = phase_t'(phase_q + 3'd1);
                cnt_n   = '0;
            end else begin
                cnt_n   = cnt_q + 32'd1;
            end
            // Entering DONE leaves the last pair on the outputs.
            if (phase_n != PH_DONE) begin
                op1_n = shape_op1(phase_n, na_c);
                op2_n = shape_op2(phase_n, nb_c);
            end
        end
    end

    assign phase   = phase_q;
    assign busy    = (phase_q != PH_IDLE) && (phase_q != PH_DONE);
    assign valid   = busy;
    assign done    = (phase_q == PH_DONE);
    assign op1     = op1_q;
    assign op2     = op2_q;
    assign vec_idx = vidx_q;

endmodule
